// File: rtl/vga_scan_timer_if.sv
// Signal bundle between the VGA scan timer, the frame buffer read port and the board pins.
// FRAME_IRQ exists only when VGA_FRAME_IRQ_EN is defined.
interface vga_scan_timer_if;
  logic [15:0] CONFIG_COLOURS;
  logic        VGA_DATA;
  logic        DPR_CLK;
  logic [14:0] VGA_ADDR;
  logic        VGA_HS;
  logic        VGA_VS;
  logic [7:0]  VGA_COLOUR;
`ifdef VGA_FRAME_IRQ_EN
  logic        FRAME_IRQ;

  modport master (
    input  CONFIG_COLOURS, VGA_DATA,
    output DPR_CLK, VGA_ADDR, VGA_HS, VGA_VS, VGA_COLOUR, FRAME_IRQ
  );

  modport slave (
    output CONFIG_COLOURS, VGA_DATA,
    input  DPR_CLK, VGA_ADDR, VGA_HS, VGA_VS, VGA_COLOUR, FRAME_IRQ
  );
`else
  modport master (
    input  CONFIG_COLOURS, VGA_DATA,
    output DPR_CLK, VGA_ADDR, VGA_HS, VGA_VS, VGA_COLOUR
  );

  modport slave (
    output CONFIG_COLOURS, VGA_DATA,
    input  DPR_CLK, VGA_ADDR, VGA_HS, VGA_VS, VGA_COLOUR
  );
`endif
endinterface

// File: rtl/vga_scan_timer.sv
// 640x480@60Hz VGA timing generator and 160x120 1-bit frame buffer reader with a 2-tick output pipeline.
// Optional FRAME_IRQ pulse at the start of vertical blank is enabled by defining VGA_FRAME_IRQ_EN.
module vga_scan_timer #(
  parameter logic [9:0] H_TOTAL   = 10'd800,
  parameter logic [9:0] H_SYNC    = 10'd96,
  parameter logic [9:0] H_DISP_ST = 10'd144,
  parameter logic [9:0] H_DISP_EN = 10'd784,
  parameter logic [9:0] V_TOTAL   = 10'd521,
  parameter logic [9:0] V_SYNC    = 10'd2,
  parameter logic [9:0] V_DISP_ST = 10'd31,
  parameter logic [9:0] V_DISP_EN = 10'd511
) (
  input  logic             CLK,
  input  logic             RESET,
  vga_scan_timer_if.master bus
);

  logic [1:0]  div_q, div_d;
  logic        dprClk_q, dprClk_d;
  logic [9:0]  hCnt_q, hCnt_d;
  logic [9:0]  vCnt_q, vCnt_d;
  logic [14:0] addr_q, addr_d;
  logic        hs1_q, hs1_d;
  logic        vs1_q, vs1_d;
  logic        vis1_q, vis1_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [7:0]  colour_q, colour_d;

  logic        tick;
  logic        visibleNow;
  logic [7:0]  xPix;
  logic [6:0]  yPix;

  assign tick       = (div_q == 2'd3);
  assign visibleNow = (hCnt_q >= H_DISP_ST) && (hCnt_q < H_DISP_EN) &&
                      (vCnt_q >= V_DISP_ST) && (vCnt_q < V_DISP_EN);
  assign xPix       = 8'((hCnt_q - H_DISP_ST) >> 2);
  assign yPix       = 7'((vCnt_q - V_DISP_ST) >> 2);

  // Stage 1 registers address/sync/visible from the counters; stage 2 turns them into pin values.
  always_comb begin
    div_d    = div_q + 2'd1;
    dprClk_d = div_q[1];
    hCnt_d   = hCnt_q;
    vCnt_d   = vCnt_q;
    addr_d   = addr_q;
    hs1_d    = hs1_q;
    vs1_d    = vs1_q;
    vis1_d   = vis1_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    colour_d = colour_q;
    if (tick) begin
      if (hCnt_q == H_TOTAL - 10'd1) begin
        hCnt_d = '0;
        vCnt_d = (vCnt_q == V_TOTAL - 10'd1) ? 10'd0 : vCnt_q + 10'd1;
      end else begin
        hCnt_d = hCnt_q + 10'd1;
      end
      if (visibleNow) begin
        addr_d = {yPix, xPix};
      end
      hs1_d    = (hCnt_q >= H_SYNC);
      vs1_d    = (vCnt_q >= V_SYNC);
      vis1_d   = visibleNow;
      hs_d     = hs1_q;
      vs_d     = vs1_q;
      colour_d = vis1_q ? (bus.VGA_DATA ? bus.CONFIG_COLOURS[15:8] : bus.CONFIG_COLOURS[7:0])
                        : 8'h00;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      div_q    <= '0;
      dprClk_q <= 1'b0;
      hCnt_q   <= '0;
      vCnt_q   <= '0;
      addr_q   <= '0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      vis1_q   <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      colour_q <= '0;
    end else begin
      div_q    <= div_d;
      dprClk_q <= dprClk_d;
      hCnt_q   <= hCnt_d;
      vCnt_q   <= vCnt_d;
      addr_q   <= addr_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      vis1_q   <= vis1_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      colour_q <= colour_d;
    end
  end

  assign bus.DPR_CLK    = dprClk_q;
  assign bus.VGA_ADDR   = addr_q;
  assign bus.VGA_HS     = hs_q;
  assign bus.VGA_VS     = vs_q;
  assign bus.VGA_COLOUR = colour_q;

`ifdef VGA_FRAME_IRQ_EN
  logic irq1_q, irq1_d;
  logic irq_q, irq_d;

  // Stage 2 output is only high on the tick edge itself, giving a single-CLK pulse.
  always_comb begin
    irq1_d = irq1_q;
    if (tick) begin
      irq1_d = (hCnt_q == 10'd0) && (vCnt_q == V_DISP_EN);
    end
    irq_d = tick && irq1_q;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      irq1_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      irq1_q <= irq1_d;
      irq_q  <= irq_d;
    end
  end

  assign bus.FRAME_IRQ = irq_q;
`endif

endmodule

// File: tb/tb_vga_scan_timer.sv
// Scoreboard bench for vga_scan_timer: horizontal timing at full size, vertical timing on a 10-line frame.
// Expected events are queued by the stimulus process and consumed by a negedge monitor.
module tb_vga_scan_timer;

  typedef struct {
    int cyc;
    int len;
  } evT;

  typedef struct {
    int cyc;
    int val;
  } pixT;

  logic clk  = 1'b0;
  logic rstN = 1'b1;
  int   relCyc = 0;
  int   total = 0;
  int   bad = 0;

  evT   hsQ[$];
  evT   vsQ[$];
  evT   irqQ[$];
  int   dprQ[$];
  pixT  addrQ[$];
  pixT  colQ[$];

  vga_scan_timer_if bus ();

  vga_scan_timer #(
    .V_TOTAL  (10'd10),
    .V_SYNC   (10'd2),
    .V_DISP_ST(10'd3),
    .V_DISP_EN(10'd8)
  ) dut (
    .CLK  (clk),
    .RESET(rstN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Frame buffer stand-in: checkerboard of 4x4 blocks, bit = X[0] ^ Y[0].
  assign bus.VGA_DATA = bus.VGA_ADDR[0] ^ bus.VGA_ADDR[8];

  always @(posedge clk or negedge rstN) begin
    if (!rstN) relCyc <= 0;
    else       relCyc <= relCyc + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h (relCyc=%0d)", name, actual, expected, relCyc);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_hs"}, int'(bus.VGA_HS), 1);
    checkOutput({tag, "_vs"}, int'(bus.VGA_VS), 1);
    checkOutput({tag, "_colour"}, int'(bus.VGA_COLOUR), 0);
    checkOutput({tag, "_addr"}, int'(bus.VGA_ADDR), 0);
    checkOutput({tag, "_dprclk"}, int'(bus.DPR_CLK), 0);
`ifdef VGA_FRAME_IRQ_EN
    checkOutput({tag, "_irq"}, int'(bus.FRAME_IRQ), 0);
`endif
  endtask

  task automatic checkDrained(input string tag);
    checkOutput({tag, "_hs_left"}, hsQ.size(), 0);
    checkOutput({tag, "_vs_left"}, vsQ.size(), 0);
    checkOutput({tag, "_dpr_left"}, dprQ.size(), 0);
    checkOutput({tag, "_addr_left"}, addrQ.size(), 0);
    checkOutput({tag, "_col_left"}, colQ.size(), 0);
`ifdef VGA_FRAME_IRQ_EN
    checkOutput({tag, "_irq_left"}, irqQ.size(), 0);
`endif
  endtask

  // Monitor state
  logic hsPrev = 1'b1, vsPrev = 1'b1, dprPrev = 1'b0, irqPrev = 1'b0;
  bit   hsPend = 0, vsPend = 0, irqPend = 0;
  int   hsFallAt, vsFallAt, irqRiseAt, hsLen, vsLen, irqLen;

  always @(negedge clk) begin
    evT  e;
    pixT p;
    int  d;
    if (!rstN) begin
      hsPend  = 0;
      vsPend  = 0;
      irqPend = 0;
    end else begin
      if (hsPrev && !bus.VGA_HS && hsQ.size() > 0) begin
        e = hsQ.pop_front();
        checkOutput("hs_fall_cyc", relCyc, e.cyc);
        hsFallAt = relCyc; hsLen = e.len; hsPend = 1;
      end
      if (!hsPrev && bus.VGA_HS && hsPend) begin
        checkOutput("hs_low_len", relCyc - hsFallAt, hsLen);
        hsPend = 0;
      end
      if (vsPrev && !bus.VGA_VS && vsQ.size() > 0) begin
        e = vsQ.pop_front();
        checkOutput("vs_fall_cyc", relCyc, e.cyc);
        vsFallAt = relCyc; vsLen = e.len; vsPend = 1;
      end
      if (!vsPrev && bus.VGA_VS && vsPend) begin
        checkOutput("vs_low_len", relCyc - vsFallAt, vsLen);
        vsPend = 0;
      end
      if (!dprPrev && bus.DPR_CLK && dprQ.size() > 0) begin
        d = dprQ.pop_front();
        checkOutput("dpr_rise_cyc", relCyc, d);
      end
`ifdef VGA_FRAME_IRQ_EN
      if (!irqPrev && bus.FRAME_IRQ) begin
        if (irqQ.size() > 0) begin
          e = irqQ.pop_front();
          checkOutput("irq_rise_cyc", relCyc, e.cyc);
          irqRiseAt = relCyc; irqLen = e.len; irqPend = 1;
        end else begin
          checkOutput("irq_extra_at", relCyc, 0);
        end
      end
      if (irqPrev && !bus.FRAME_IRQ && irqPend) begin
        checkOutput("irq_len", relCyc - irqRiseAt, irqLen);
        irqPend = 0;
      end
`endif
      if (addrQ.size() > 0 && addrQ[0].cyc <= relCyc) begin
        p = addrQ.pop_front();
        if (p.cyc == relCyc) checkOutput("addr", int'(bus.VGA_ADDR), p.val);
        else                 checkOutput("addr_missed_cyc", relCyc, p.cyc);
      end
      if (colQ.size() > 0 && colQ[0].cyc <= relCyc) begin
        p = colQ.pop_front();
        if (p.cyc == relCyc) checkOutput("colour", int'(bus.VGA_COLOUR), p.val);
        else                 checkOutput("colour_missed_cyc", relCyc, p.cyc);
      end
    end
    hsPrev  = bus.VGA_HS;
    vsPrev  = bus.VGA_VS;
    dprPrev = bus.DPR_CLK;
`ifdef VGA_FRAME_IRQ_EN
    irqPrev = bus.FRAME_IRQ;
`endif
  end

  // Position p = V*800 + H: address visible at relCyc 4p+4, colour/sync at 4p+8.
  task automatic applyStimulus();
    int addrCyc[10] = '{10176, 10180, 10196, 12736, 12740, 19788, 22996, 23012, 25536, 26404};
    int addrVal[10] = '{15'h000, 15'h000, 15'h001, 15'h09F, 15'h09F,
                        15'h000, 15'h101, 15'h102, 15'h19F, 15'h19F};
    int colCyc[10]  = '{10180, 10184, 10200, 12740, 12744, 19792, 23000, 23016, 25540, 26408};
    int colVal[10]  = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h1C, 8'h1C, 8'hE0, 8'h1C, 8'h00};

    bus.CONFIG_COLOURS = 16'hFF00;
    #1 rstN = 1'b0;
    repeat (3) @(negedge clk);
    #1 checkResetState("rst0");

    for (int k = 0; k < 14; k++) hsQ.push_back('{8 + 3200 * k, 384});
    vsQ.push_back('{8, 6400});
    vsQ.push_back('{32008, 6400});
    for (int k = 0; k < 5; k++) dprQ.push_back(3 + 4 * k);
    for (int k = 0; k < 10; k++) begin
      addrQ.push_back('{addrCyc[k], addrVal[k]});
      colQ.push_back('{colCyc[k], colVal[k]});
    end
`ifdef VGA_FRAME_IRQ_EN
    irqQ.push_back('{25608, 1});
`endif

    @(negedge clk);
    #2 rstN = 1'b1;
    while (relCyc < 16002) @(negedge clk);
    bus.CONFIG_COLOURS = 16'hE01C;
    while (relCyc < 44002) @(negedge clk);
    checkDrained("run1");

    #2 rstN = 1'b0;
    #1 checkResetState("rst1");
    hsQ.delete(); vsQ.delete(); dprQ.delete(); addrQ.delete(); colQ.delete(); irqQ.delete();
    hsQ.push_back('{8, 384});
    vsQ.push_back('{8, 6400});
    for (int k = 0; k < 3; k++) dprQ.push_back(3 + 4 * k);
    repeat (2) @(negedge clk);
    #2 rstN = 1'b1;
    while (relCyc < 500) @(negedge clk);
    checkDrained("run2");
  endtask

  initial begin
    applyStimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached (relCyc=%0d)", relCyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
